// File: rtl/delay_line_sequencer.sv
// Per-sample delay-path sequencer: ADC capture, shared single-port RAM write/read, DAC load.
// Define ECHO_MIX_EN to output the average of the current and delayed samples instead of the pure delay.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a sample tick
// WAIT_ADC  | conversion started, waiting for adc_valid or the timeout
// WRITE     | RAM write of the new sample at wr_ptr
// READ      | RAM read address of the delayed sample presented
// READ_WAIT | RAM read data returning, result registered to the DAC
// OUTPUT    | dac_load pulse, write pointer advances
module delay_line_sequencer #(
  parameter int DATA_W      = 10,
  parameter int ADDR_W      = 13,
  parameter int DLY_SHIFT   = 4,
  parameter int ADC_TIMEOUT = 2000
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [8:0]        dly_sel,
  output logic              adc_start,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_load,
  output logic              busy,
  output logic              overrun,
  output logic              adc_timeout
);

  localparam int CNT_W = $clog2(ADC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ADC,
    WRITE,
    READ,
    READ_WAIT,
    OUTPUT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [8:0]        dly_q;
  logic [DATA_W-1:0] smp;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  cnt;

  // Modulo-2^ADDR_W subtraction gives the wrap-around read position for free.
  assign rd_addr = wr_ptr - (ADDR_W'(dly_q) << DLY_SHIFT);

`ifdef ECHO_MIX_EN
  logic [DATA_W:0] mix_sum;
  assign mix_sum = {1'b0, smp} + {1'b0, ram_rdata};
  assign result  = mix_sum[DATA_W:1];
`else
  assign result = ram_rdata;
`endif

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      cnt         <= '0;
      dly_q       <= '0;
      smp         <= '0;
      adc_start   <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      dac_data    <= '0;
      dac_load    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      adc_timeout <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      ram_we    <= 1'b0;
      dac_load  <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            dly_q     <= dly_sel;
            cnt       <= '0;
            adc_start <= 1'b1;
            busy      <= 1'b1;
            state     <= WAIT_ADC;
          end
        end
        WAIT_ADC: begin
          if (adc_valid) begin
            smp       <= adc_data;
            ram_we    <= 1'b1;
            ram_addr  <= wr_ptr;
            ram_wdata <= adc_data;
            state     <= WRITE;
          end else if (cnt == CNT_W'(ADC_TIMEOUT - 1)) begin
            // No conversion arrived: rewrite the last good sample so the line keeps moving.
            adc_timeout <= 1'b1;
            ram_we      <= 1'b1;
            ram_addr    <= wr_ptr;
            ram_wdata   <= smp;
            state       <= WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          ram_addr <= rd_addr;
          state    <= READ;
        end
        READ: begin
          state <= READ_WAIT;
        end
        READ_WAIT: begin
          dac_data <= result;
          dac_load <= 1'b1;
          state    <= OUTPUT;
        end
        OUTPUT: begin
          wr_ptr <= wr_ptr + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
